// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer and its neighbours.
//   state_t  : sequencer states IDLE / FETCH / EXEC / DONE
//   PC_W     : program counter / instruction-memory address width
//   IW       : instruction word width
//   OPW      : opcode width (opcode is the top OPW bits of the word)
//   LUT_W    : branch-target table index width (index is the low LUT_W bits)
//   OP_BR    : branch opcode, shared with the control decoder
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W  = 10;
  localparam int IW    = 9;
  localparam int OPW   = 3;
  localparam int LUT_W = 4;

  localparam logic [OPW-1:0] OP_BR = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut
// Combinational branch-target ROM: 2**LUT_W entries of PC_W bits.
// Ports:
//   idx     in   LUT_W  table index (low bits of the branch instruction)
//   target  out  PC_W   branch destination address
// ---------------------------------------------------------------------------
module branch_lut
  import fetch_pkg::*;
#(
  parameter int TGT_W = fetch_pkg::PC_W,
  parameter int IDX_W = fetch_pkg::LUT_W
) (
  input  logic [IDX_W-1:0] idx,
  output logic [TGT_W-1:0] target
);

  always_comb begin
    // NOTE: default assigned first so every path drives target; no latch.
    target = '0;
    case (int'(idx))
      0:  target = TGT_W'(20);
      1:  target = TGT_W'(16);
      2:  target = TGT_W'(32);
      3:  target = TGT_W'(8);
      4:  target = TGT_W'(100);
      5:  target = TGT_W'(200);
      6:  target = TGT_W'(300);
      7:  target = TGT_W'(400);
      8:  target = TGT_W'(500);
      9:  target = TGT_W'(600);
      10: target = TGT_W'(700);
      11: target = TGT_W'(800);
      12: target = TGT_W'(900);
      13: target = TGT_W'(1000);
      14: target = TGT_W'(1022);
      15: target = TGT_W'(1023);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Program sequencer: owns the PC, reads instruction words from synchronous
// instruction memory, presents the opcode to the control decoder and acts on
// its Branch / Halt decisions. Two cycles per instruction (FETCH, EXEC).
//
// Ports:
//   Clk          in   1     clock, rising edge
//   Reset        in   1     asynchronous active-high reset
//   Start        in   1     run program from address 0 (accepted in IDLE/DONE)
//   Branch       in   1     take branch; sampled at end of EXEC only
//   Halt         in   1     stop program; sampled at end of EXEC only
//   imem_data    in   IW    instruction word, one cycle after imem_rd
//   imem_addr    out  PC_W  read address (= pc)
//   imem_rd      out  1     read strobe (FETCH only)
//   instr        out  IW    current instruction word (held after EXEC)
//   instr_op     out  OPW   opcode field of instr
//   instr_valid  out  1     instr/instr_op valid (EXEC only)
//   pc           out  PC_W  program counter
//   Done         out  1     program finished (DONE state)
//   instr_count  out  16    retired-instruction count
//
// Configuration macro INSTR_COUNT_EN: when defined, instr_count counts EXEC
// cycles (saturating, cleared on Reset and accepted Start); when undefined
// there are no counter flops and instr_count is tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W  = fetch_pkg::PC_W,
  parameter int IW    = fetch_pkg::IW,
  parameter int OPW   = fetch_pkg::OPW,
  parameter int LUT_W = fetch_pkg::LUT_W
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic            Halt,
  input  logic [IW-1:0]   imem_data,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  output logic [IW-1:0]   instr,
  output logic [OPW-1:0]  instr_op,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            Done,
  output logic [15:0]     instr_count
);

  localparam logic [PC_W-1:0] PC_LAST = '1;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [IW-1:0]   instr_q;
  logic [PC_W-1:0] br_target;

  branch_lut #(
    .TGT_W (PC_W),
    .IDX_W (LUT_W)
  ) u_branch_lut (
    .idx    (instr[LUT_W-1:0]),
    .target (br_target)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      instr_q <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == EXEC) instr_q <= imem_data;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    imem_rd     = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_next = FETCH;
          pc_next    = '0;
        end
      end
      FETCH: begin
        imem_rd    = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (Halt) begin
          state_next = DONE;
        end else if (Branch) begin
          pc_next    = br_target;
          state_next = FETCH;
        end else if (pc == PC_LAST) begin
          // End of address space: stop rather than wrap to 0.
          state_next = DONE;
        end else begin
          pc_next    = pc + PC_W'(1);
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory data arrives during EXEC; show it directly then, and keep the
  // captured copy on the output afterwards so instr stays stable.
  assign instr     = instr_valid ? imem_data : instr_q;
  assign instr_op  = instr[IW-1 -: OPW];
  assign imem_addr = pc;
  assign Done      = (state == DONE);

`ifdef INSTR_COUNT_EN
  logic [15:0] count_q;
  logic        start_accept;

  assign start_accept = Start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else if (start_accept) begin
      count_q <= '0;
    end else if ((state == EXEC) && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A behavioural program interpreter
// predicts the fetch-address trace, final pc and retired count; a negedge
// monitor records fetches and verifies every EXEC word against the ROM.
// Honours INSTR_COUNT_EN when predicting instr_count.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [2:0] OP_HALT = 3'b110;

  logic        Clk, Reset, Start, Branch, Halt;
  logic [8:0]  imem_data;
  logic [9:0]  imem_addr, pc;
  logic        imem_rd, instr_valid, Done;
  logic [8:0]  instr;
  logic [2:0]  instr_op;
  logic [15:0] instr_count;

  instr_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Branch      (Branch),
    .Halt        (Halt),
    .imem_data   (imem_data),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .instr       (instr),
    .instr_op    (instr_op),
    .instr_valid (instr_valid),
    .pc          (pc),
    .Done        (Done),
    .instr_count (instr_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- environment: ROM, control decoder, noise -------------
  logic [8:0] rom [0:1023];
  int lut_tab [16] = '{20, 16, 32, 8, 100, 200, 300, 400,
                       500, 600, 700, 800, 900, 1000, 1022, 1023};

  initial imem_data = '0;
  always @(posedge Clk) if (imem_rd) imem_data <= rom[imem_addr];

  bit   br_en    = 1'b1;
  int   br_limit = -1;   // branches allowed before the decoder halts instead
  int   taken    = 0;
  logic noise_b  = 1'b0;
  logic noise_h  = 1'b0;

  always @(negedge Clk) begin
    noise_b <= 1'($urandom);
    noise_h <= 1'($urandom);
  end

  always @(posedge Clk) begin
    if (Reset || Start) taken <= 0;
    else if (instr_valid && Branch) taken <= taken + 1;
  end

  // Branch/Halt carry random junk outside EXEC; the sequencer must ignore it.
  always_comb begin
    Branch = noise_b;
    Halt   = noise_h;
    if (instr_valid) begin
      Branch = 1'b0;
      Halt   = (instr_op == OP_HALT);
      if (instr_op == OP_BR && br_en) begin
        if (br_limit >= 0 && taken >= br_limit) Halt = 1'b1;
        else Branch = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------------------------------------
  int         cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [9:0] fetch_q [$];
  logic [9:0] last_addr = '0;
  bit         prev_rd = 1'b0;
  int         last_valid_cyc = 0;
  int         mon_err = 0;

  always @(negedge Clk) begin
    if (instr_valid) begin
      last_valid_cyc <= cyc;
      if (!prev_rd || instr !== rom[last_addr] || instr_op !== rom[last_addr][8:6]) begin
        mon_err <= mon_err + 1;
        $display("exec word error at addr %0d: instr=%h rd_before=%b want %h",
                 last_addr, instr, prev_rd, rom[last_addr]);
      end
    end
    if (imem_rd) begin
      fetch_q.push_back(imem_addr);
      last_addr <= imem_addr;
    end
    prev_rd <= imem_rd;
  end

  // ---------------- reference model --------------------------------------
  int          exp_q [$];
  int          exp_pc, exp_n;
  bit          exp_done;
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          fetch_base = 0;
  int          err_base = 0;

  // Interpret the program: each step executes one instruction.
  task automatic ref_run(input int cap);
    int p, t;
    logic [8:0] w;
    exp_q.delete();
    p = 0; t = 0; exp_n = 0; exp_done = 1'b0;
    while (!exp_done && exp_n < cap) begin
      exp_q.push_back(p);
      w = rom[p];
      exp_n++;
      if (w[8:6] == OP_HALT) exp_done = 1'b1;
      else if (w[8:6] == OP_BR && br_en && br_limit >= 0 && t >= br_limit) exp_done = 1'b1;
      else if (w[8:6] == OP_BR && br_en) begin p = lut_tab[w[3:0]]; t++; end
      else if (p == 1023) exp_done = 1'b1;
      else p++;
    end
    exp_pc = p;
`ifdef INSTR_COUNT_EN
    exp_cnt = (exp_n > 65535) ? 16'hFFFF : 16'(exp_n);
`else
    exp_cnt = 16'h0;
`endif
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  // Pulse Start from IDLE/DONE and check the first FETCH cycle.
  task automatic launch(input string name);
    fetch_base = fetch_q.size();
    err_base   = mon_err;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    n_checks++;
    if (Done !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 10'd0)
      $display("FAIL %s start: Done=%b rd=%b addr=%0d, required 0/1/0", name, Done, imem_rd, imem_addr);
    else n_pass++;
    n_checks++;
    if (instr_count !== 16'h0) $display("FAIL %s start_count: %0d, required 0", name, instr_count);
    else n_pass++;
  endtask

  task automatic wait_check(input string name);
    int k, got_n, mism;
    k = 0;
    while (Done !== 1'b1 && k < 2 * exp_n + 20) begin @(negedge Clk); k++; end
    n_checks++;
    if (Done !== 1'b1) $display("FAIL %s done: Done=%b after %0d cycles, required 1", name, Done, k);
    else n_pass++;
    n_checks++;
    if (cyc - last_valid_cyc !== 1)
      $display("FAIL %s done_latency: %0d cycles after last EXEC, required 1", name, cyc - last_valid_cyc);
    else n_pass++;
    got_n = fetch_q.size() - fetch_base;
    mism = -1;
    for (int i = 0; i < exp_q.size() && i < got_n; i++)
      if (mism < 0 && fetch_q[fetch_base + i] !== 10'(exp_q[i])) mism = i;
    n_checks++;
    if (got_n != exp_q.size() || mism >= 0)
      $display("FAIL %s fetch_seq: %0d fetches (first diff idx %0d), required %0d fetches",
               name, got_n, mism, exp_q.size());
    else n_pass++;
    n_checks++;
    if (pc !== 10'(exp_pc)) $display("FAIL %s pc: %0d, required %0d", name, pc, exp_pc);
    else n_pass++;
    n_checks++;
    if (instr_count !== exp_cnt) $display("FAIL %s count: %0d, required %0d", name, instr_count, exp_cnt);
    else n_pass++;
    n_checks++;
    if (mon_err !== err_base) $display("FAIL %s exec_words: %0d bad EXEC cycles, required 0", name, mon_err - err_base);
    else n_pass++;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (fetch_q.size() - fetch_base != got_n || Done !== 1'b1 || pc !== 10'(exp_pc))
      $display("FAIL %s hold: extra fetches %0d Done=%b pc=%0d, required 0/1/%0d",
               name, fetch_q.size() - fetch_base - got_n, Done, pc, exp_pc);
    else n_pass++;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if ({imem_rd, instr_valid, Done, pc, imem_addr, instr, instr_op, instr_count} !== '0)
      $display("FAIL reset_outputs: rd=%b v=%b done=%b pc=%0d addr=%0d instr=%h cnt=%0d, required all 0",
               imem_rd, instr_valid, Done, pc, imem_addr, instr, instr_count);
    else n_pass++;
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    n_checks++;
    if (fetch_q.size() != 0 || Done !== 1'b0)
      $display("FAIL reset_idle: %0d fetches Done=%b, required 0/0", fetch_q.size(), Done);
    else n_pass++;
  endtask

  task automatic load_linear();
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = {3'(i + 1), 6'($urandom)};
    rom[4] = {OP_HALT, 6'($urandom)};
  endtask

  task automatic test_linear();
    br_en = 1'b1; br_limit = -1;
    load_linear();
    ref_run(5000);
    launch("linear");
    wait_check("linear");
  endtask

  task automatic test_branch();
    for (int b = 1; b >= 0; b--) begin
      br_en = 1'(b); br_limit = -1;
      clear_rom();
      rom[0] = 9'b001_010101;
      rom[1] = 9'b010_001100;
      rom[2] = {OP_BR, 2'b10, 4'd3};
      rom[3] = 9'b011_000000;
      rom[4] = {OP_HALT, 6'd0};
      rom[8] = {OP_HALT, 6'd1};
      ref_run(5000);
      launch(b ? "branch_taken" : "branch_not_taken");
      wait_check(b ? "branch_taken" : "branch_not_taken");
    end
  endtask

  task automatic test_tight_loop();
    br_en = 1'b1; br_limit = 3;
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = {3'(i % 6), 6'($urandom)};
    rom[8] = {OP_BR, 2'b01, 4'd3};   // lut[3] = 8: branches to itself
    ref_run(5000);
    launch("tight_loop");
    wait_check("tight_loop");
    br_limit = -1;
  endtask

  task automatic test_back_to_back();
    int k;
    br_en = 1'b1; br_limit = -1;
    load_linear();
    ref_run(5000);
    launch("start_busy");
    k = 0;
    while (instr_valid !== 1'b1 && k < 10) begin @(negedge Clk); k++; end
    @(negedge Clk);   // FETCH of address 1
    @(negedge Clk);   // EXEC of address 1
    Start = 1'b1;     // held across EXEC->FETCH and FETCH->EXEC edges
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    wait_check("start_busy");
    launch("start_in_done");
    wait_check("start_in_done");
  endtask

  task automatic test_reset_mid();
    int k, base;
    br_en = 1'b1; br_limit = -1;
    load_linear();
    launch("reset_mid");
    k = 0;
    while (instr_valid !== 1'b1 && k < 10) begin @(negedge Clk); k++; end
    #1 Reset = 1'b1;
    #1;
    n_checks++;
    if ({imem_rd, instr_valid, Done, pc, instr, instr_count} !== '0)
      $display("FAIL reset_mid_outputs: rd=%b v=%b done=%b pc=%0d instr=%h cnt=%0d, required all 0",
               imem_rd, instr_valid, Done, pc, instr, instr_count);
    else n_pass++;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    base = fetch_q.size();
    repeat (6) @(negedge Clk);
    n_checks++;
    if (fetch_q.size() != base || Done !== 1'b0 || pc !== 10'd0)
      $display("FAIL reset_mid_idle: %0d fetches Done=%b pc=%0d, required 0/0/0",
               fetch_q.size() - base, Done, pc);
    else n_pass++;
  endtask

  task automatic test_pc_end();
    br_en = 1'b1; br_limit = -1;
    clear_rom();
    rom[0]    = {OP_BR, 2'b00, 4'd15};   // lut[15] = 1023
    rom[1023] = 9'b001_000111;
    ref_run(5000);
    launch("pc_end");
    wait_check("pc_end");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      br_en = 1'($urandom_range(0, 3) != 0); br_limit = -1;
      clear_rom();
      for (int i = 0; i < 23; i++) begin
        if ($urandom_range(0, 5) == 0) rom[i] = {OP_BR, 2'($urandom), 4'($urandom_range(4, 15))};
        else rom[i] = {3'($urandom_range(0, 5)), 6'($urandom)};
      end
      rom[23] = {OP_HALT, 6'($urandom)};
      ref_run(5000);
      launch("random");
      wait_check("random");
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    clear_rom();
    test_reset();
    test_linear();
    test_branch();
    test_tight_loop();
    test_back_to_back();
    test_reset_mid();
    test_pc_end();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
